// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 block sequencer.
// Holds the 32-bit word type, the MD5 initial chaining value, the
// sequencer state encoding and a modular add helper.
package md5_pkg;

    typedef logic [31:0] word_t;

    // MD5 initial chaining value, one constant per lane
    localparam word_t IV_A = 32'h67452301;
    localparam word_t IV_B = 32'hefcdab89;
    localparam word_t IV_C = 32'h98badcfe;
    localparam word_t IV_D = 32'h10325476;

    // Number of 16-step rounds applied to each block
    localparam int ROUNDS = 4;

    // Sequencer states; IDLE is zero so a cleared state register is idle
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_ADD   = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    // Lane addition modulo 2^32; the carry out is dropped on purpose
    function automatic word_t add32(input word_t x, input word_t y);
        return x + y;
    endfunction

endpackage

// File: rtl/md5_block_ctrl_if.sv
// Bus bundle of the MD5 block sequencer: block input stream, round
// datapath control/result, and digest output stream.
//
// Handshake rule for both streams (blk_* and dig_*): a transfer happens
// on a rising clock edge where valid and ready are both 1. The producer
// holds valid and its payload stable until that edge; ready may change
// freely and never depends combinationally on valid.
interface md5_block_ctrl_if #(
    parameter int N = 32
);

    // Block input stream from the message padder
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic         blk_first_i;
    logic         blk_last_i;
    logic [511:0] blk_data_i;

    // Round datapath control and operands
    logic         dp_load_o;
    logic [1:0]   dp_round_o;
    logic [N-1:0] dp_a_o;
    logic [N-1:0] dp_b_o;
    logic [N-1:0] dp_c_o;
    logic [N-1:0] dp_d_o;
    logic [511:0] dp_m_o;

    // Round datapath result
    logic         dp_done_i;
    logic [N-1:0] dp_a_i;
    logic [N-1:0] dp_b_i;
    logic [N-1:0] dp_c_i;
    logic [N-1:0] dp_d_i;

    // Digest output stream
    logic         dig_valid_o;
    logic         dig_ready_i;
    logic [127:0] dig_o;

    // Sequencer side
    modport master (
        input  blk_valid_i, blk_first_i, blk_last_i, blk_data_i,
        output blk_ready_o,
        output dp_load_o, dp_round_o, dp_a_o, dp_b_o, dp_c_o, dp_d_o, dp_m_o,
        input  dp_done_i, dp_a_i, dp_b_i, dp_c_i, dp_d_i,
        output dig_valid_o, dig_o,
        input  dig_ready_i
    );

    // Environment side: padder, round datapath and digest consumer
    modport slave (
        output blk_valid_i, blk_first_i, blk_last_i, blk_data_i,
        input  blk_ready_o,
        input  dp_load_o, dp_round_o, dp_a_o, dp_b_o, dp_c_o, dp_d_o, dp_m_o,
        output dp_done_i, dp_a_i, dp_b_i, dp_c_i, dp_d_i,
        input  dig_valid_o, dig_o,
        output dig_ready_i
    );

endinterface

// File: rtl/md5_chain_add.sv
// MD5 chaining value register with its four-lane modular adder.
// Reset and i_load_iv put the MD5 IV into the register; i_add_en folds
// the working value of a finished block into the chain.
module md5_chain_add
    import md5_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load_iv,
    input  logic  i_add_en,
    input  word_t i_work_a,
    input  word_t i_work_b,
    input  word_t i_work_c,
    input  word_t i_work_d,
    output word_t o_chain_a,
    output word_t o_chain_b,
    output word_t o_chain_c,
    output word_t o_chain_d
);

    word_t r_chain_a;
    word_t r_chain_b;
    word_t r_chain_c;
    word_t r_chain_d;

    word_t w_sum_a;
    word_t w_sum_b;
    word_t w_sum_c;
    word_t w_sum_d;

    assign w_sum_a = add32(r_chain_a, i_work_a);
    assign w_sum_b = add32(r_chain_b, i_work_b);
    assign w_sum_c = add32(r_chain_c, i_work_c);
    assign w_sum_d = add32(r_chain_d, i_work_d);

    // Chain register: IV on reset or message start, sum on block end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain_a <= IV_A;
            r_chain_b <= IV_B;
            r_chain_c <= IV_C;
            r_chain_d <= IV_D;
        end else if (i_load_iv) begin
            r_chain_a <= IV_A;
            r_chain_b <= IV_B;
            r_chain_c <= IV_C;
            r_chain_d <= IV_D;
        end else if (i_add_en) begin
            r_chain_a <= w_sum_a;
            r_chain_b <= w_sum_b;
            r_chain_c <= w_sum_c;
            r_chain_d <= w_sum_d;
        end
    end

    assign o_chain_a = r_chain_a;
    assign o_chain_b = r_chain_b;
    assign o_chain_c = r_chain_c;
    assign o_chain_d = r_chain_d;

endmodule

// File: rtl/md5_block_ctrl.sv
// Block-level sequencer for the MD5 round datapath.
// Takes one 512-bit block per handshake, runs the four 16-step rounds
// through the external datapath, folds the result into the chaining
// value and, on the last block of a message, offers the digest.
// A round that never reports done within TIMEOUT cycles aborts the
// block and sets a sticky error; the chain is left untouched.
// Only N = 32 is meaningful; the port widths follow N for clarity.
module md5_block_ctrl
    import md5_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    md5_block_ctrl_if.master       bus,
    output logic                   busy_o,
    output logic                   err_o,
    output logic [2:0]             dbg_state_o
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LOAD  = ST_LOAD;
    localparam logic [2:0] S_ROUND = ST_ROUND;
    localparam logic [2:0] S_ADD   = ST_ADD;
    localparam logic [2:0] S_OUT   = ST_OUT;

    localparam int              TMO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [1:0]      RND_LAST = 2'(ROUNDS - 1);

    // Sequencer state
    logic [2:0]       r_state;
    logic [1:0]       r_round;
    logic [TMO_W-1:0] r_tmo;
    logic             r_last;
    logic             r_err;

    // Block data and working A..D carried between rounds
    logic [511:0]     r_m;
    logic [N-1:0]     r_wa;
    logic [N-1:0]     r_wb;
    logic [N-1:0]     r_wc;
    logic [N-1:0]     r_wd;

    // Chaining value from the adder
    word_t            w_chain_a;
    word_t            w_chain_b;
    word_t            w_chain_c;
    word_t            w_chain_d;

    logic             w_in_idle;
    logic             w_blk_ready;
    logic             w_accept;
    logic             w_load_iv;
    logic             w_add_en;
    logic             w_round_done;

    assign w_in_idle    = (r_state == S_IDLE);
    // Ready is held low while reset is applied so no block is taken then
    assign w_blk_ready  = w_in_idle & ~rst_i;
    assign w_accept     = bus.blk_valid_i & w_blk_ready;
    assign w_load_iv    = w_accept & bus.blk_first_i;
    assign w_add_en     = (r_state == S_ADD);
    // Done only counts while a round is running; a done coincident with
    // the load pulse or arriving in any other state is ignored
    assign w_round_done = (r_state == S_ROUND) & bus.dp_done_i;

    md5_chain_add u_chain (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_load_iv (w_load_iv),
        .i_add_en  (w_add_en),
        .i_work_a  (r_wa),
        .i_work_b  (r_wb),
        .i_work_c  (r_wc),
        .i_work_d  (r_wd),
        .o_chain_a (w_chain_a),
        .o_chain_b (w_chain_b),
        .o_chain_c (w_chain_c),
        .o_chain_d (w_chain_d)
    );

    // Control FSM: round sequencing, timeout watch and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_round <= '0;
            r_tmo   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_last  <= bus.blk_last_i;
                        r_round <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tmo   <= '0;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (bus.dp_done_i) begin
                        if (r_round == RND_LAST) begin
                            r_state <= S_ADD;
                        end else begin
                            r_round <= r_round + 2'd1;
                            r_state <= S_LOAD;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        // Datapath is stuck: drop the block, keep the chain
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_ADD: begin
                    r_state <= r_last ? S_OUT : S_IDLE;
                end
                S_OUT: begin
                    if (bus.dig_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Block capture and working-value update between rounds
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_m  <= '0;
            r_wa <= '0;
            r_wb <= '0;
            r_wc <= '0;
            r_wd <= '0;
        end else if (w_accept) begin
            r_m  <= bus.blk_data_i;
            r_wa <= bus.blk_first_i ? IV_A : w_chain_a;
            r_wb <= bus.blk_first_i ? IV_B : w_chain_b;
            r_wc <= bus.blk_first_i ? IV_C : w_chain_c;
            r_wd <= bus.blk_first_i ? IV_D : w_chain_d;
        end else if (w_round_done) begin
            r_wa <= bus.dp_a_i;
            r_wb <= bus.dp_b_i;
            r_wc <= bus.dp_c_i;
            r_wd <= bus.dp_d_i;
        end
    end

    assign bus.blk_ready_o = w_blk_ready;

    assign bus.dp_load_o   = (r_state == S_LOAD);
    assign bus.dp_round_o  = r_round;
    assign bus.dp_a_o      = r_wa;
    assign bus.dp_b_o      = r_wb;
    assign bus.dp_c_o      = r_wc;
    assign bus.dp_d_o      = r_wd;
    assign bus.dp_m_o      = r_m;

    // Digest is only driven while offered; zero otherwise
    assign bus.dig_valid_o = (r_state == S_OUT);
    assign bus.dig_o       = (r_state == S_OUT) ?
                             {w_chain_d, w_chain_c, w_chain_b, w_chain_a} : 128'd0;

    assign busy_o          = ~w_in_idle;
    assign err_o           = r_err;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_md5_block_ctrl.sv
// Bench for md5_block_ctrl: drives blocks, models the round datapath
// with a configurable done latency, and scores digests against golden
// values from a reference MD5 compression function.
module tb_md5_block_ctrl;
    import md5_pkg::*;

    localparam logic [127:0] DIG_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [127:0] DIG_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
    localparam logic [127:0] IV_ALL    = {IV_D, IV_C, IV_B, IV_A};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] dbg_state;
    logic busy;
    logic err;

    md5_block_ctrl_if #(.N(32)) bus ();

    md5_block_ctrl #(.N(32), .TIMEOUT(64)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .busy_o      (busy),
        .err_o       (err),
        .dbg_state_o (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    int ld = 17;
    int stall_round = -1;
    logic [127:0] exp_q[$];

    logic [31:0] k_tab [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    int s_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // One 16-step MD5 round; returns {D,C,B,A}
    function automatic logic [127:0] md5_round(input int r, input logic [31:0] ia, input logic [31:0] ib,
                                               input logic [31:0] ic, input logic [31:0] id,
                                               input logic [511:0] m);
        logic [31:0] a, b, c, d, f, t;
        int g;
        a = ia; b = ib; c = ic; d = id;
        for (int j = 0; j < 16; j++) begin
            case (r)
                0:       begin f = (b & c) | (~b & d); g = j;                end
                1:       begin f = (d & b) | (~d & c); g = (5 * j + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * j + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * j) % 16;     end
            endcase
            t = a + f + k_tab[r * 16 + j] + m[g * 32 +: 32];
            a = d; d = c; c = b;
            b = b + rotl(t, s_tab[r * 4 + j % 4]);
        end
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] md5_compress(input logic [127:0] ch, input logic [511:0] m);
        logic [127:0] w;
        w = ch;
        for (int r = 0; r < 4; r++) begin
            w = md5_round(r, w[31:0], w[63:32], w[95:64], w[127:96], m);
        end
        return {ch[127:96] + w[127:96], ch[95:64] + w[95:64], ch[63:32] + w[63:32], ch[31:0] + w[31:0]};
    endfunction

    // Round datapath model: answers each load after ld cycles unless stalled
    initial begin : dp_model
        logic [127:0] res;
        bit aborted;
        bus.dp_done_i = 1'b0;
        bus.dp_a_i = '0; bus.dp_b_i = '0; bus.dp_c_i = '0; bus.dp_d_i = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.dp_load_o && (int'(bus.dp_round_o) != stall_round)) begin
                res = md5_round(int'(bus.dp_round_o), bus.dp_a_o, bus.dp_b_o, bus.dp_c_o, bus.dp_d_o, bus.dp_m_o);
                aborted = 1'b0;
                for (int k = 0; k < ld; k++) begin
                    @(posedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    #1;
                    bus.dp_done_i = 1'b1;
                    {bus.dp_d_i, bus.dp_c_i, bus.dp_b_i, bus.dp_a_i} = res;
                    @(posedge clk);
                    #1;
                    bus.dp_done_i = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every digest transfer pops one expected value
    initial begin : sb_monitor
        logic [127:0] exp;
        logic have;
        forever begin
            @(negedge clk);
            if (!rst && bus.dig_valid_o && bus.dig_ready_i) begin
                have = (exp_q.size() != 0);
                check_eq("digest_expected", have, 1'b1);
                if (have) begin
                    exp = exp_q.pop_front();
                    check_eq("digest", bus.dig_o, exp);
                end
            end
        end
    end

    // Driver tasks
    task automatic send_block(input logic [511:0] data, input logic first, input logic last);
        logic acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        bus.blk_valid_i = 1'b1;
        bus.blk_data_i  = data;
        bus.blk_first_i = first;
        bus.blk_last_i  = last;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.blk_ready_o) begin
                acc = 1'b1;
                break;
            end
        end
        check_eq("blk_accept", acc, 1'b1);
        @(posedge clk);
        #1;
        bus.blk_valid_i = 1'b0;
        // Scramble the inputs so a datapath that reads them unlatched goes wrong
        bus.blk_data_i  = {16{$urandom()}};
        bus.blk_first_i = 1'($urandom_range(0, 1));
        bus.blk_last_i  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(output logic saw_dig);
        saw_dig = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (bus.dig_valid_o) saw_dig = 1'b1;
            if (!busy) break;
        end
        check_eq("idle_reached", busy, 1'b0);
    endtask

    task automatic wait_dig_rise(output int n);
        n = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            n++;
            if (bus.dig_valid_o) break;
        end
        check_eq("dig_rise_seen", bus.dig_valid_o, 1'b1);
    endtask

    // Main stimulus
    initial begin : main
        logic [511:0] blk_empty, blk_abc, blk_a1, blk_a2;
        logic [127:0] dig_two;
        logic saw;
        logic found;
        int n;

        blk_empty = '0; blk_empty[31:0] = 32'h00000080;
        blk_abc   = '0; blk_abc[31:0]   = 32'h80636261; blk_abc[14*32 +: 32] = 32'h00000018;
        blk_a1    = '0;
        for (int k = 0; k < 14; k++) blk_a1[k*32 +: 32] = 32'h61616161;
        blk_a1[14*32 +: 32] = 32'h00000080;
        blk_a2    = '0; blk_a2[14*32 +: 32] = 32'h000001c0;
        dig_two   = md5_compress(md5_compress(IV_ALL, blk_a1), blk_a2);

        bus.blk_valid_i = 1'b0;
        bus.blk_first_i = 1'b0;
        bus.blk_last_i  = 1'b0;
        bus.blk_data_i  = '0;
        bus.dig_ready_i = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_state", dbg_state, 3'(ST_IDLE));
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_dig_valid", bus.dig_valid_o, 1'b0);
        check_eq("rst_dp_load", bus.dp_load_o, 1'b0);
        check_eq("rst_dp_abcd", {bus.dp_d_o, bus.dp_c_o, bus.dp_b_o, bus.dp_a_o}, 128'd0);
        check_eq("rst_dp_m", bus.dp_m_o[127:0] | bus.dp_m_o[255:128] | bus.dp_m_o[383:256] | bus.dp_m_o[511:384], 128'd0);
        check_eq("rst_dp_round", bus.dp_round_o, 2'd0);
        check_eq("rst_dig", bus.dig_o, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", bus.blk_ready_o, 1'b1);

        // Empty message, Ld = 17
        ld = 17;
        exp_q.push_back(DIG_EMPTY);
        send_block(blk_empty, 1'b1, 1'b1);
        wait_idle(saw);

        // "abc" with digest latency measured from the accept cycle
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b1, 1'b1);
        wait_dig_rise(n);
        check_eq("abc_latency", n, 74);
        wait_idle(saw);

        // Two-block message with minimum datapath latency, then restart from IV
        ld = 1;
        send_block(blk_a1, 1'b1, 1'b0);
        wait_idle(saw);
        check_eq("b1_no_digest", saw, 1'b0);
        check_eq("b1_ready_back", bus.blk_ready_o, 1'b1);
        exp_q.push_back(dig_two);
        send_block(blk_a2, 1'b0, 1'b1);
        wait_idle(saw);
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b1, 1'b1);
        wait_idle(saw);

        // Digest backpressure
        ld = 3;
        bus.dig_ready_i = 1'b0;
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b1, 1'b1);
        wait_dig_rise(n);
        for (int k = 0; k < 10; k++) begin
            check_eq("bp_valid", bus.dig_valid_o, 1'b1);
            check_eq("bp_dig_stable", bus.dig_o, DIG_ABC);
            check_eq("bp_blk_ready", bus.blk_ready_o, 1'b0);
            check_eq("bp_dp_load", bus.dp_load_o, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.dig_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_valid_drop", bus.dig_valid_o, 1'b0);
        check_eq("bp_idle", dbg_state, 3'(ST_IDLE));

        // Datapath timeout in round 2 of the second block
        ld = 5;
        send_block(blk_a1, 1'b1, 1'b0);
        wait_idle(saw);
        stall_round = 2;
        send_block(blk_a2, 1'b0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.dp_load_o && bus.dp_round_o == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("tmo_r2_load", found, 1'b1);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        check_eq("tmo_cycles", n, 65);
        check_eq("tmo_state", dbg_state, 3'(ST_IDLE));
        check_eq("tmo_dig_valid", bus.dig_valid_o, 1'b0);
        stall_round = -1;
        repeat (5) @(negedge clk);
        check_eq("tmo_err_sticky", err, 1'b1);
        exp_q.push_back(dig_two);
        send_block(blk_a2, 1'b0, 1'b1);
        wait_idle(saw);
        check_eq("tmo_err_kept", err, 1'b1);

        // Asynchronous reset in the middle of a round
        ld = 17;
        send_block(blk_abc, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_state", dbg_state, 3'(ST_IDLE));
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_err", err, 1'b0);
        check_eq("arst_dp_load", bus.dp_load_o, 1'b0);
        check_eq("arst_dp_abcd", {bus.dp_d_o, bus.dp_c_o, bus.dp_b_o, bus.dp_a_o}, 128'd0);
        check_eq("arst_dp_m_lo", bus.dp_m_o[127:0], 128'd0);
        check_eq("arst_dig_valid", bus.dig_valid_o, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("arst_ready", bus.blk_ready_o, 1'b1);
        // first=0 right after reset still chains from IV
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b0, 1'b1);
        wait_idle(saw);
        check_eq("arst_err_clear", err, 1'b0);

        repeat (5) @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/md5_block_ctrl.md
Name: md5_block_ctrl

Overview:
- Block-level sequencer for the MD5 round datapath.
- Accepts one 512-bit message block per valid/ready handshake and drives the four 16-step rounds in order (round select 0..3), chaining A..D between them.
- After round 3, adds the result to the chaining value. On the last block of a message, presents the 128-bit digest on a valid/ready output.
- Sits between the message padder upstream and the round datapath.

Parameters:
- N, 32, word width. Only 32 is supported.
- TIMEOUT, 64, max cycles to wait for dp_done_i in one round before aborting.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- blk_valid_i  in  1  block available.
- blk_ready_o  out  1  controller can accept a block.
- blk_first_i  in  1  block starts a message; chaining is reloaded with IV.
- blk_last_i  in  1  block ends a message; the digest is emitted.
- blk_data_i  in  512  message words; word k in bits [32k+31:32k].
- dp_load_o  out  1  one-cycle pulse that loads A..D and the round into the datapath.
- dp_round_o  out  2  round select for the datapath.
- dp_a_o, dp_b_o, dp_c_o, dp_d_o  out  N each  round input words.
- dp_m_o  out  512  registered message block, held stable for the whole block.
- dp_done_i  in  1  datapath finished 16 steps.
- dp_a_i, dp_b_i, dp_c_i, dp_d_i  in  N each  round result, valid when dp_done_i=1.
- dig_valid_o  out  1  digest valid.
- dig_ready_i  in  1  digest consumer ready.
- dig_o  out  128  digest; A in [31:0], B [63:32], C [95:64], D [127:96].
- busy_o  out  1  state is not IDLE.
- err_o  out  1  sticky datapath timeout; cleared only by reset.

Behaviour:
- **Reset** (async):
  - state=IDLE, round=0, err_o=0, dig_valid_o=0, dp_load_o=0.
  - dp_*_o=0, dp_m_o=0, dig_o=0.
  - Chaining regs = IV: A=67452301, B=efcdab89, C=98badcfe, D=10325476 (hex).
  - blk_ready_o=1 once reset releases.
- **IDLE:**
  - blk_ready_o=1.
  - On blk_valid_i&blk_ready_o:
    - Latch blk_data_i into the M reg and blk_last_i into the last flag.
    - If blk_first_i: chain<=IV and working<=IV; else working<=chain.
    - round<=0; go to LOAD.
- **LOAD:** dp_load_o=1 for exactly one cycle, with dp_round_o=round and dp_a..d_o=working. Go to ROUND; clear the timeout counter.
- **ROUND:**
  - dp_round_o and dp_*_o are held.
  - On dp_done_i: working<=dp_a..d_i. If round==3 go to ADD; else round<=round+1 and go to LOAD.
  - The timeout counter increments each ROUND cycle without done. On reaching TIMEOUT: err_o<=1, go to IDLE, chain unchanged, no digest.
- **ADD:** each chain word <= (chain + working) mod 2^32; carries are discarded. If last go to OUT, else go to IDLE.
- **OUT:**
  - dig_valid_o=1 with dig_o=chain.
  - dig_o is stable while dig_ready_i=0.
  - On dig_ready_i, go to IDLE; dig_valid_o drops the next cycle.
- **Control rules:**
  - blk_ready_o=0 in every state except IDLE.
  - dp_done_i is ignored outside ROUND, including a done in the same cycle as dp_load_o.
- **Latency:** if dp_done_i arrives Ld cycles after the dp_load_o cycle (Ld≥1), each round takes 1+Ld cycles. dig_valid_o first asserts 4·(1+Ld)+2 cycles after the accept cycle.
- **Reset mid-operation:** the block in flight is discarded and the chain returns to IV.
- **blk_first_i=0 after reset:** the block chains from IV, since that is the reset value.
- **Throughput:** one block per 4·(1+Ld)+2 cycles for non-last blocks; there is no overlap between blocks.

Decomposition:
- md5_pkg holds:
  - the word type logic [31:0];
  - the IV_A..IV_D constants;
  - the state enum {IDLE, LOAD, ROUND, ADD, OUT};
  - ROUNDS=4.
- One sub-module: md5_chain_add, a four-lane 32-bit modular adder with chain register enable, reset to IV.
- The FSM, round counter and timeout counter stay in md5_block_ctrl.

Test Plan:
- **Empty message:** bench datapath model with Ld=17. Single block, first=last=1, word0=00000080, all other words 0 → dig_o[31:0]=d98c1dd4, [63:32]=04b2008f, [95:64]=980980e9, [127:96]=7e42f8ec, i.e. MD5 d41d8cd98f00b204e9800998ecf8427e.
- **"abc":** word0=80636261, word14=00000018, rest 0, first=last=1 → A..D = 98500190, b04fd23c, 7d3f96d6, 727fe128. dig_valid_o rises exactly 4·18+2=74 cycles after accept.
- **Two-block message:** 56-byte "a"×56, padded. Block 1 with first=1 last=0 → no dig_valid_o, blk_ready_o returns to 1. Block 2 with first=0 last=1 → digest matches the golden model. A third block with first=1 restarts from IV.
- **Backpressure:** dig_ready_i held 0 for 10 cycles in OUT → dig_o stable, blk_ready_o=0, dp_load_o=0. Raising dig_ready_i → IDLE next cycle.
- **Timeout:** datapath model never asserts done in round 2 → err_o=1 after 64 ROUND cycles, state IDLE, chain unchanged. The next block still completes correctly and err_o stays 1.
- **Async reset mid-ROUND:** assert rst_i between clock edges → outputs zero immediately, blk_ready_o=1 after release, subsequent "abc" digest correct.
